// File: rtl/rob_retire_pkg.sv
// Shared types for the ROB retire unit: retire queue entry layout and FSM states.
package rob_retire_pkg;

    localparam int PHYS_W    = 7;
    localparam int ROB_IDX_W = 8;
    localparam int PC_W      = 64;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] idx;
        logic [PHYS_W-1:0]    rd_phys;
        logic [PHYS_W-1:0]    old_phys;
        logic                 is_store;
        logic                 br_misp;
        logic [PC_W-1:0]      br_tgt;
    } retire_entry_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ST_WAIT = 2'd1,
        FLUSH   = 2'd2
    } retire_state_e;

    function automatic logic releases_reg(input retire_entry_t e);
        return e.old_phys != '0;
    endfunction

endpackage

// File: rtl/rob_retire_unit_retire_queue.sv
// In-order FIFO of retire entries with simultaneous push/pop and a
// synchronous clear that takes priority over both.
module retire_queue
    import rob_retire_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  retire_entry_t      push_data,
    input  logic               pop,
    input  logic               clear,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output retire_entry_t      head
);

    retire_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != CNT_W'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

    always_comb begin
        count = cnt;
        empty = (cnt == '0);
        head  = mem[rd_ptr];
    end

endmodule

// File: rtl/rob_retire_unit.sv
// In-order retire stage behind the ROB commit port: frees old mappings, hands stores
// to the store buffer, flushes on mispredict. ROB_RETIRE_PERF_EN adds perf counters.
module rob_retire_unit
    import rob_retire_pkg::*;
#(
    parameter int unsigned Q_DEPTH      = 4,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  commit_valid_i,
    input  logic [ROB_IDX_W-1:0]  commit_idx_i,
    input  logic [PHYS_W-1:0]     commit_rd_phys_i,
    input  logic [PHYS_W-1:0]     commit_old_phys_i,
    input  logic                  commit_is_store_i,
    input  logic                  commit_branch_misp_i,
    input  logic [PC_W-1:0]       commit_branch_target_i,
    output logic                  commit_ready_o,
    output logic                  free_valid_o,
    output logic [PHYS_W-1:0]     free_phys_o,
    output logic                  st_commit_valid_o,
    output logic [ROB_IDX_W-1:0]  st_commit_idx_o,
    input  logic                  st_commit_ready_i,
    output logic                  flush_o,
    output logic                  redirect_valid_o,
    output logic [PC_W-1:0]       redirect_pc_o,
    output logic [63:0]           instret_o
`ifdef ROB_RETIRE_PERF_EN
    ,
    output logic [31:0]           perf_misp_o,
    output logic [31:0]           perf_store_o
`endif
);

    localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);
    localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

    retire_state_e   state_q;
    retire_state_e   state_d;
    logic [FC_W-1:0] flush_cnt_q;
    logic [FC_W-1:0] flush_cnt_d;
    logic            started_q;
    logic            ready_q;

    retire_entry_t   push_entry;
    retire_entry_t   q_head;
    logic [CNT_W-1:0] q_count;
    logic            q_empty;
    logic            q_push;
    logic            q_clear;
    logic            retire;
    logic            st_valid;
    logic [CNT_W:0]  occupancy;
    logic            unused_rd_phys;

    always_comb begin
        push_entry          = '0;
        push_entry.idx      = commit_idx_i;
        push_entry.rd_phys  = commit_rd_phys_i;
        push_entry.old_phys = commit_old_phys_i;
        push_entry.is_store = commit_is_store_i;
        push_entry.br_misp  = commit_branch_misp_i;
        push_entry.br_tgt   = commit_branch_target_i;
    end

    retire_queue #(
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (retire),
        .clear     (q_clear),
        .count     (q_count),
        .empty     (q_empty),
        .head      (q_head)
    );

    // started_q keeps the credit low until the first edge after reset release.
    always_comb begin
        occupancy      = {1'b0, q_count} + {{CNT_W{1'b0}}, ready_q};
        commit_ready_o = started_q && (state_q == RUN) &&
                         (occupancy < (CNT_W + 1)'(Q_DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        retire      = 1'b0;
        st_valid    = 1'b0;
        q_clear     = 1'b0;
        case (state_q)
            RUN: begin
                if (!q_empty) begin
                    if (q_head.is_store) begin
                        st_valid = 1'b1;
                        if (st_commit_ready_i) retire = 1'b1;
                        else                   state_d = ST_WAIT;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                st_valid = !q_empty;
                if (!q_empty && st_commit_ready_i) begin
                    retire  = 1'b1;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (flush_cnt_q <= FC_W'(1)) begin
                    state_d     = RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        // A retiring mispredict overrides the store return path and drops younger work.
        if (retire && q_head.br_misp) begin
            state_d     = FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES);
            q_clear     = 1'b1;
        end
        q_push            = commit_valid_i && (state_q != FLUSH) && !q_clear;
        flush_o           = (state_q == FLUSH);
        st_commit_valid_o = st_valid;
        st_commit_idx_o   = st_valid ? q_head.idx : '0;
        unused_rd_phys    = ^q_head.rd_phys;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q        <= 1'b0;
            ready_q          <= 1'b0;
            free_valid_o     <= 1'b0;
            free_phys_o      <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            instret_o        <= '0;
        end else begin
            started_q        <= 1'b1;
            ready_q          <= commit_ready_o;
            free_valid_o     <= retire && releases_reg(q_head);
            free_phys_o      <= (retire && releases_reg(q_head)) ? q_head.old_phys : '0;
            redirect_valid_o <= retire && q_head.br_misp;
            if (retire && q_head.br_misp) redirect_pc_o <= q_head.br_tgt;
            instret_o        <= instret_o + 64'(retire);
        end
    end

`ifdef ROB_RETIRE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_misp_o  <= '0;
            perf_store_o <= '0;
        end else if (retire) begin
            if (q_head.br_misp && (perf_misp_o != '1))   perf_misp_o  <= perf_misp_o + 1'b1;
            if (q_head.is_store && (perf_store_o != '1)) perf_store_o <= perf_store_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_retire_unit.sv
// Scoreboard bench for rob_retire_unit: directed packet streams, store stalls,
// mispredict flushes and mid-operation resets.
`timescale 1ns/1ps
module tb_rob_retire_unit;
    import rob_retire_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit_valid_i = 1'b0;
    logic [7:0]  commit_idx_i = '0;
    logic [6:0]  commit_rd_phys_i = '0;
    logic [6:0]  commit_old_phys_i = '0;
    logic        commit_is_store_i = 1'b0;
    logic        commit_branch_misp_i = 1'b0;
    logic [63:0] commit_branch_target_i = '0;
    logic        st_commit_ready_i = 1'b1;
    logic        commit_ready_o;
    logic        free_valid_o;
    logic [6:0]  free_phys_o;
    logic        st_commit_valid_o;
    logic [7:0]  st_commit_idx_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;
    logic [63:0] instret_o;

    always #5 clk = ~clk;

    rob_retire_unit #(.Q_DEPTH(4), .FLUSH_CYCLES(3)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .commit_valid_i         (commit_valid_i),
        .commit_idx_i           (commit_idx_i),
        .commit_rd_phys_i       (commit_rd_phys_i),
        .commit_old_phys_i      (commit_old_phys_i),
        .commit_is_store_i      (commit_is_store_i),
        .commit_branch_misp_i   (commit_branch_misp_i),
        .commit_branch_target_i (commit_branch_target_i),
        .commit_ready_o         (commit_ready_o),
        .free_valid_o           (free_valid_o),
        .free_phys_o            (free_phys_o),
        .st_commit_valid_o      (st_commit_valid_o),
        .st_commit_idx_o        (st_commit_idx_o),
        .st_commit_ready_i      (st_commit_ready_i),
        .flush_o                (flush_o),
        .redirect_valid_o       (redirect_valid_o),
        .redirect_pc_o          (redirect_pc_o),
        .instret_o              (instret_o)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n_free_seen = 0;

    retire_entry_t tx_q[$];
    logic [6:0]    exp_free[$];
    logic [63:0]   exp_redir[$];
    logic [7:0]    exp_st[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic retire_entry_t mk(input logic [7:0] idx, input logic [6:0] oldp,
                                         input logic st, input logic misp, input logic [63:0] tgt);
        retire_entry_t e;
        e.idx      = idx;
        e.rd_phys  = oldp + 7'd32;
        e.old_phys = oldp;
        e.is_store = st;
        e.br_misp  = misp;
        e.br_tgt   = tgt;
        return e;
    endfunction

    // ROB model: a packet goes out the cycle after ready was seen high.
    logic          rdy_s;
    retire_entry_t tx_p;
    always begin
        @(negedge clk);
        rdy_s = commit_ready_o;
        @(posedge clk);
        #1;
        if (rdy_s && tx_q.size() > 0) begin
            tx_p = tx_q.pop_front();
            commit_valid_i         = 1'b1;
            commit_idx_i           = tx_p.idx;
            commit_rd_phys_i       = tx_p.rd_phys;
            commit_old_phys_i      = tx_p.old_phys;
            commit_is_store_i      = tx_p.is_store;
            commit_branch_misp_i   = tx_p.br_misp;
            commit_branch_target_i = tx_p.br_tgt;
        end else begin
            commit_valid_i = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    logic [6:0]  m_free;
    logic [63:0] m_redir;
    logic [7:0]  m_st;
    always @(negedge clk) begin
        if (rst_n) begin
            if (free_valid_o) begin
                n_free_seen++;
                if (exp_free.size() == 0) check("free_unexpected", 64'(free_valid_o), 64'd0);
                else begin
                    m_free = exp_free.pop_front();
                    check("free_phys", 64'(free_phys_o), 64'(m_free));
                end
            end
            if (redirect_valid_o) begin
                if (exp_redir.size() == 0) check("redirect_unexpected", 64'(redirect_valid_o), 64'd0);
                else begin
                    m_redir = exp_redir.pop_front();
                    check("redirect_pc", redirect_pc_o, m_redir);
                end
            end
            if (st_commit_valid_o && st_commit_ready_i) begin
                if (exp_st.size() == 0) check("store_unexpected", 64'(st_commit_valid_o), 64'd0);
                else begin
                    m_st = exp_st.pop_front();
                    check("store_idx", 64'(st_commit_idx_o), 64'(m_st));
                end
            end
        end
    end

    task automatic wait_st_valid(input string name);
        int k = 0;
        do begin @(negedge clk); k++; end while (!st_commit_valid_o && k < 20);
        check({name, "_seen"}, 64'(st_commit_valid_o), 64'd1);
    endtask

    task automatic wait_flush(input string name);
        int k = 0;
        do begin @(negedge clk); k++; end while (!flush_o && k < 20);
        check({name, "_seen"}, 64'(flush_o), 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 64'({free_valid_o, free_phys_o, st_commit_valid_o, st_commit_idx_o,
                                  flush_o, redirect_valid_o, commit_ready_o}), 64'd0);
        check({name, "_pc"}, redirect_pc_o, 64'd0);
        check({name, "_instret"}, instret_o, 64'd0);
    endtask

    task automatic flush_window(input string name);
        int fl = 0;
        int rd = 0;
        int fr = 0;
        repeat (12) begin
            @(negedge clk);
            fl += int'(flush_o);
            rd += int'(redirect_valid_o);
            if (flush_o && commit_ready_o) fr++;
        end
        check({name, "_flush_cycles"}, 64'(fl), 64'd3);
        check({name, "_redirect_pulses"}, 64'(rd), 64'd1);
        check({name, "_ready_in_flush"}, 64'(fr), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int drop;
        int k;
        int early;

        // Reset state and credit release timing
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", 64'(commit_ready_o), 64'd0);
        @(negedge clk);
        check("ready_after_first_edge", 64'(commit_ready_o), 64'd1);

        // Continuous stream of 10 plain packets
        for (int i = 1; i <= 10; i++) begin
            tx_q.push_back(mk(8'(i - 1), 7'(i), 1'b0, 1'b0, 64'd0));
            exp_free.push_back(7'(i));
        end
        drop = 0;
        k = 0;
        while (tx_q.size() > 0 && k < 100) begin
            @(negedge clk);
            if (!commit_ready_o) drop++;
            k++;
        end
        check("stream_ready_drops", 64'(drop), 64'd0);
        repeat (10) @(negedge clk);
        check("stream_instret", instret_o, 64'd10);

        // old_phys 0 is never freed but still retires
        tx_q.push_back(mk(8'h0A, 7'd0, 1'b0, 1'b0, 64'd0));
        repeat (6) @(negedge clk);
        check("zero_phys_instret", instret_o, 64'd11);

        // Store held off by the store buffer, younger packets behind it
        @(posedge clk); #1 st_commit_ready_i = 1'b0;
        tx_q.push_back(mk(8'h20, 7'd11, 1'b1, 1'b0, 64'd0));
        exp_st.push_back(8'h20);
        exp_free.push_back(7'd11);
        for (int i = 0; i < 5; i++) begin
            tx_q.push_back(mk(8'h21 + 8'(i), 7'd12 + 7'(i), 1'b0, 1'b0, 64'd0));
            exp_free.push_back(7'd12 + 7'(i));
        end
        wait_st_valid("st_stall");
        check("st_hold_c1", 64'(st_commit_idx_o), 64'h20);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check("st_hold", 64'({st_commit_valid_o, st_commit_idx_o}), 64'h120);
        end
        check("st_stall_ready_low", 64'(commit_ready_o), 64'd0);
        @(posedge clk); #1 st_commit_ready_i = 1'b1;
        repeat (20) @(negedge clk);
        check("st_instret", instret_o, 64'd17);

        // Mispredict behind a stalled store: Y1 queued and Y2 in flight are dropped
        @(posedge clk); #1 st_commit_ready_i = 1'b0;
        tx_q.push_back(mk(8'h30, 7'd20, 1'b1, 1'b0, 64'd0));
        tx_q.push_back(mk(8'h31, 7'd21, 1'b0, 1'b1, 64'h8000_1000));
        tx_q.push_back(mk(8'h32, 7'd22, 1'b0, 1'b0, 64'd0));
        tx_q.push_back(mk(8'h33, 7'd23, 1'b0, 1'b0, 64'd0));
        exp_st.push_back(8'h30);
        exp_free.push_back(7'd20);
        exp_free.push_back(7'd21);
        exp_redir.push_back(64'h8000_1000);
        wait_st_valid("misp_st");
        repeat (4) @(negedge clk);
        @(posedge clk); #1 st_commit_ready_i = 1'b1;
        flush_window("misp");
        repeat (6) @(negedge clk);
        check("misp_instret", instret_o, 64'd19);

        // Store that is also a mispredict
        @(posedge clk); #1 st_commit_ready_i = 1'b0;
        tx_q.push_back(mk(8'h40, 7'd30, 1'b1, 1'b1, 64'h4000_0200));
        tx_q.push_back(mk(8'h41, 7'd31, 1'b0, 1'b0, 64'd0));
        exp_st.push_back(8'h40);
        exp_free.push_back(7'd30);
        exp_redir.push_back(64'h4000_0200);
        wait_st_valid("sm_st");
        early = 0;
        repeat (4) begin
            @(negedge clk);
            early += int'(redirect_valid_o | flush_o | free_valid_o);
        end
        check("sm_no_early_redirect", 64'(early), 64'd0);
        @(posedge clk); #1 st_commit_ready_i = 1'b1;
        flush_window("sm");
        repeat (6) @(negedge clk);
        check("sm_instret", instret_o, 64'd20);

        // Reset asserted during FLUSH
        tx_q.push_back(mk(8'h50, 7'd40, 1'b0, 1'b1, 64'h0000_0000_0000_ABC0));
        exp_free.push_back(7'd40);
        exp_redir.push_back(64'h0000_0000_0000_ABC0);
        wait_flush("rst_flush");
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_all_zero("rst_in_flush");
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset asserted during ST_WAIT; this store is aborted
        @(posedge clk); #1 st_commit_ready_i = 1'b0;
        tx_q.push_back(mk(8'h51, 7'd41, 1'b1, 1'b0, 64'd0));
        wait_st_valid("rst_st");
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_all_zero("rst_in_st_wait");
        repeat (2) @(negedge clk);
        @(posedge clk); #1 st_commit_ready_i = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_first_cycle", 64'({commit_ready_o, free_valid_o, redirect_valid_o, flush_o}), 64'd0);
        @(negedge clk);
        check("post_rst_ready", 64'(commit_ready_o), 64'd1);

        // Normal retirement resumes after reset
        tx_q.push_back(mk(8'h60, 7'd5, 1'b0, 1'b0, 64'd0));
        exp_free.push_back(7'd5);
        repeat (6) @(negedge clk);
        check("post_rst_instret", instret_o, 64'd1);

        check("free_pulse_total", 64'(n_free_seen), 64'd21);
        check("exp_free_left", 64'(exp_free.size()), 64'd0);
        check("exp_redir_left", 64'(exp_redir.size()), 64'd0);
        check("exp_st_left", 64'(exp_st.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
